// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: FSM encoding and default widths.
package mem_wb_stage_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEF_REG_NUM_BITWIDTH = 5;
    localparam int DEF_WORD_BITWIDTH    = 32;
    localparam int DEF_TIMEOUT_CYCLES   = 16;
endpackage

// File: rtl/mem_wb_stage_dmem_req_ctrl.sv
// Data-memory request controller: issues one request per aligned access,
// holds it until ack or timeout, and reports the per-cycle outcome to the top.
module dmem_req_ctrl
    import mem_wb_stage_pkg::*;
#(
    parameter int WORD_BITWIDTH  = DEF_WORD_BITWIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     access,
    input  logic                     is_write,
    input  logic [WORD_BITWIDTH-1:0] addr,
    input  logic [WORD_BITWIDTH-1:0] wdata,
    input  logic                     ack,
    output logic                     stall,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [WORD_BITWIDTH-1:0] dmem_addr,
    output logic [WORD_BITWIDTH-1:0] dmem_wdata,
    output logic                     accept,
    output logic                     pass,
    output logic                     misalign,
    output logic                     done,
    output logic                     done_load,
    output logic                     timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt;
    logic [WORD_BITWIDTH-1:0] addr_q, wdata_q;
    logic                     we_q;
    logic                     aligned;

    assign aligned = (addr[1:0] == 2'b00);

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        accept     = 1'b0;
        pass       = 1'b0;
        misalign   = 1'b0;
        done       = 1'b0;
        done_load  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = WAIT;
                end else if (access) begin
                    misalign = 1'b1;
                end else begin
                    pass = 1'b1;
                end
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                // ack wins over a timeout landing in the same cycle
                if (ack) begin
                    done      = 1'b1;
                    done_load = !we_q;
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // IDLE stall is a pure function of the inputs, so reset must mask it
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= '0;
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= is_write;
            end else if (state == WAIT && stall) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage front-end plus the MEM/WB pipeline register; memory handshaking
// lives in dmem_req_ctrl.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int REG_NUM_BITWIDTH = DEF_REG_NUM_BITWIDTH,
    parameter int WORD_BITWIDTH    = DEF_WORD_BITWIDTH,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_memRead,
    input  logic                        mem_memWrite,
    input  logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    mem_regReadData2,
    input  logic                        mem_wt_memToReg,
    input  logic                        mem_wt_regWrite,
    input  logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite,
    output logic                        stall,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [WORD_BITWIDTH-1:0]    dmem_addr,
    output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
    input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
    input  logic                        dmem_ack,
    output logic                        wb_memToReg,
    output logic                        wb_regWrite,
    output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
    output logic [WORD_BITWIDTH-1:0]    wb_ALUresult,
    output logic [WORD_BITWIDTH-1:0]    wb_memReadData,
    output logic                        misalign_err,
    output logic                        timeout_err
);
    logic accept, pass, misalign, done, done_load, timeout;

    dmem_req_ctrl #(
        .WORD_BITWIDTH (WORD_BITWIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .access    (mem_memRead | mem_memWrite),
        .is_write  (mem_memWrite),
        .addr      (mem_ALUresult),
        .wdata     (mem_regReadData2),
        .ack       (dmem_ack),
        .stall     (stall),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .accept    (accept),
        .pass      (pass),
        .misalign  (misalign),
        .done      (done),
        .done_load (done_load),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_memToReg    <= 1'b0;
            wb_regWrite    <= 1'b0;
            wb_regToWrite  <= '0;
            wb_ALUresult   <= '0;
            wb_memReadData <= '0;
            misalign_err   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // bubbles only drop regWrite; the rest of MEM/WB keeps its contents
            if (accept || misalign || timeout) begin
                wb_regWrite <= 1'b0;
            end else if (done || pass) begin
                wb_memToReg   <= mem_wt_memToReg;
                wb_regWrite   <= mem_wt_regWrite;
                wb_regToWrite <= mem_wt_regToWrite;
                wb_ALUresult  <= mem_ALUresult;
            end
            if (done_load) wb_memReadData <= dmem_rdata;
            misalign_err <= misalign;
            timeout_err  <= timeout_err | timeout;
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized + directed bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;
    localparam int T = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_memRead = 0, mem_memWrite = 0, mem_wt_memToReg = 0, mem_wt_regWrite = 0;
    logic [31:0] mem_ALUresult = 0, mem_regReadData2 = 0, dmem_rdata = 0;
    logic [4:0]  mem_wt_regToWrite = 0;
    logic        dmem_ack = 0;
    logic        stall, dmem_req, dmem_we, wb_memToReg, wb_regWrite, misalign_err, timeout_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_ALUresult, wb_memReadData;
    logic [4:0]  wb_regToWrite;

    mem_wb_stage #(.REG_NUM_BITWIDTH(5), .WORD_BITWIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .mem_ALUresult(mem_ALUresult), .mem_regReadData2(mem_regReadData2),
        .mem_wt_memToReg(mem_wt_memToReg), .mem_wt_regWrite(mem_wt_regWrite),
        .mem_wt_regToWrite(mem_wt_regToWrite),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_memToReg(wb_memToReg), .wb_regWrite(wb_regWrite), .wb_regToWrite(wb_regToWrite),
        .wb_ALUresult(wb_ALUresult), .wb_memReadData(wb_memReadData),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_stall, n_req, n_we;

    // model: outstanding request plus MEM/WB contents
    logic        m_busy, m_we, m_mis, m_terr, last_stall;
    logic [31:0] m_addr, m_wdata;
    int          m_wait;
    logic        w_m2r, w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_alu, w_mem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_mis = 0; m_terr = 0; m_addr = 0; m_wdata = 0; m_wait = 0;
        w_m2r = 0; w_rw = 0; w_rd = 0; w_alu = 0; w_mem = 0; last_stall = 0;
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, "_wb_m2r"}, wb_memToReg, w_m2r);
        chk({pfx, "_wb_rw"}, wb_regWrite, w_rw);
        chk({pfx, "_wb_rd"}, wb_regToWrite, w_rd);
        chk({pfx, "_wb_alu"}, wb_ALUresult, w_alu);
        chk({pfx, "_wb_mem"}, wb_memReadData, w_mem);
        chk({pfx, "_mis"}, misalign_err, m_mis);
        chk({pfx, "_terr"}, timeout_err, m_terr);
    endtask

    // One cycle: entered at posedge+1, leaves at the next posedge+1.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic m2r, input logic rw, input logic [4:0] rdst,
                       input logic ack, input logic [31:0] rdata);
        logic acc, e_stall, nmis;
        mem_memRead = rd; mem_memWrite = wr; mem_ALUresult = a; mem_regReadData2 = wd;
        mem_wt_memToReg = m2r; mem_wt_regWrite = rw; mem_wt_regToWrite = rdst;
        dmem_ack = ack; dmem_rdata = rdata;
        #3;
        acc = rd | wr;
        if (!m_busy) e_stall = acc && (a % 4 == 0);
        else         e_stall = !ack && (m_wait != T - 1);
        chk("stall", stall, e_stall);
        chk("req", dmem_req, m_busy);
        chk("we", dmem_we, m_busy & m_we);
        chk("addr", dmem_addr, m_busy ? m_addr : 32'h0);
        chk("wdata", dmem_wdata, m_busy ? m_wdata : 32'h0);
        n_stall += int'(stall); n_req += int'(dmem_req); n_we += int'(dmem_we);
        last_stall = e_stall;
        nmis = 0;
        if (!m_busy) begin
            if (acc && (a % 4 == 0)) begin
                m_busy = 1; m_addr = a; m_wdata = wd; m_we = wr; m_wait = 0; w_rw = 0;
            end else if (acc) begin
                w_rw = 0; nmis = 1;
            end else begin
                w_m2r = m2r; w_rw = rw; w_rd = rdst; w_alu = a;
            end
        end else if (ack) begin
            w_m2r = m2r; w_rw = rw; w_rd = rdst; w_alu = a;
            if (!m_we) w_mem = rdata;
            m_busy = 0;
        end else if (m_wait == T - 1) begin
            w_rw = 0; m_terr = 1; m_busy = 0;
        end else begin
            m_wait++;
        end
        m_mis = nmis;
        @(posedge clk); #1;
        chk_regs("cyc");
    endtask

    task automatic nop();
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 5'd0, 0, 32'h0);
    endtask

    task automatic clr_cnt();
        n_stall = 0; n_req = 0; n_we = 0;
    endtask

    initial begin
        logic        rd, wr, m2r, rw, ack;
        logic [31:0] a, wd;
        logic [4:0]  rdst;
        model_reset();
        clr_cnt();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk_regs("rst");
        rst = 0;

        // non-memory op
        clr_cnt();
        cyc(0, 0, 32'h1234, 32'h0, 0, 1, 5'd5, 0, 32'h0);
        chk("s1_alu", wb_ALUresult, 32'h1234);
        chk("s1_rw", wb_regWrite, 1);
        chk("s1_rd", wb_regToWrite, 5);
        chk("s1_stall", n_stall, 0);

        // load acked in the 3rd WAIT cycle
        clr_cnt();
        cyc(1, 0, 32'h40, 32'h0, 1, 1, 5'd7, 0, 32'h0);
        cyc(1, 0, 32'h40, 32'h0, 1, 1, 5'd7, 0, 32'h0);
        cyc(1, 0, 32'h40, 32'h0, 1, 1, 5'd7, 0, 32'h0);
        cyc(1, 0, 32'h40, 32'h0, 1, 1, 5'd7, 1, 32'hDEADBEEF);
        chk("s2_mem", wb_memReadData, 32'hDEADBEEF);
        chk("s2_rw", wb_regWrite, 1);
        chk("s2_rd", wb_regToWrite, 7);
        chk("s2_req_cycles", n_req, 3);
        chk("s2_stall_cycles", n_stall, 3);

        // store with immediate ack
        clr_cnt();
        cyc(0, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 5'd0, 0, 32'h0);
        cyc(0, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 5'd0, 1, 32'h12345678);
        chk("s3_mem", wb_memReadData, 32'hDEADBEEF);
        chk("s3_we_cycles", n_we, 1);
        chk("s3_stall_cycles", n_stall, 1);

        // misaligned load
        clr_cnt();
        cyc(1, 0, 32'h41, 32'h0, 1, 1, 5'd3, 0, 32'h0);
        chk("s4_mis", misalign_err, 1);
        chk("s4_rw", wb_regWrite, 0);
        chk("s4_req", n_req, 0);
        chk("s4_stall", n_stall, 0);
        nop();
        chk("s4_mis_pulse", misalign_err, 0);

        // load that never gets acked
        clr_cnt();
        for (int i = 0; i <= T; i++) cyc(1, 0, 32'h100, 32'h0, 1, 1, 5'd4, 0, 32'h0);
        chk("s5_req_cycles", n_req, T);
        chk("s5_terr", timeout_err, 1);
        chk("s5_rw", wb_regWrite, 0);
        cyc(0, 0, 32'h55, 32'h0, 0, 1, 5'd9, 0, 32'h0);
        chk("s5_next_alu", wb_ALUresult, 32'h55);
        chk("s5_terr_held", timeout_err, 1);

        // reset during the 2nd WAIT cycle
        cyc(1, 0, 32'h200, 32'h0, 1, 1, 5'd2, 0, 32'h0);
        cyc(1, 0, 32'h200, 32'h0, 1, 1, 5'd2, 0, 32'h0);
        #1 rst = 1;
        #1;
        chk("s6_req", dmem_req, 0);
        chk("s6_stall", stall, 0);
        chk("s6_addr", dmem_addr, 0);
        model_reset();
        chk_regs("s6");
        @(posedge clk); #1;
        rst = 0;
        clr_cnt();
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 5'd0, 1, 32'hFFFF0000);
        chk("s6_ack_ignored", wb_memReadData, 0);
        chk("s6_no_req", n_req, 0);

        // random traffic; inputs held while the pipeline is stalled
        rd = 0; wr = 0; a = 0; wd = 0; m2r = 0; rw = 0; rdst = 0;
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0: begin rd = 0; wr = 0; end
                    1: begin rd = 1; wr = 0; end
                    2: begin rd = 0; wr = 1; end
                    default: begin rd = 1; wr = 1; end
                endcase
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
                wd = $urandom; m2r = 1'($urandom); rw = 1'($urandom); rdst = 5'($urandom);
            end
            ack = (i % 150 < 40) ? 1'b0 : ($urandom_range(0, 2) == 0);
            cyc(rd, wr, a, wd, m2r, rw, rdst, ack, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
